// File: rtl/pow_pkg.sv
// Shared definitions for the power-unit family (comb, pipe and sequential variants):
// FSM state encodings and default operand/exponent widths.
package pow_pkg;

  localparam int POW_WIDTH_DEFAULT     = 18;
  localparam int POW_EXP_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    POW_IDLE = 2'd0,
    POW_CALC = 2'd1,
    POW_DONE = 2'd2
  } pow_state_e;

endpackage

// File: rtl/pow_mul_wide.sv
// Combinational unsigned multiplier: WIDTH x WIDTH operands, product of PROD_WIDTH bits
// (2*WIDTH for the full product, or WIDTH when only the truncated low half is wanted).
module pow_mul_wide
  import pow_pkg::*;
#(
  parameter int WIDTH      = POW_WIDTH_DEFAULT,
  parameter int PROD_WIDTH = 2 * WIDTH
) (
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  output logic [PROD_WIDTH-1:0] prod
);

  logic [PROD_WIDTH-1:0] a_ext;
  logic [PROD_WIDTH-1:0] b_ext;

  // Widen before multiplying so the product is formed at the full output width.
  assign a_ext = PROD_WIDTH'(a);
  assign b_ext = PROD_WIDTH'(b);
  assign prod  = a_ext * b_ext;

endmodule

// File: rtl/pow_var_exp_seq.sv
// Sequential square-and-multiply power unit: result = n ** exp mod 2**WIDTH, run/ready handshake.
// Define POW_VAR_EXP_SEQ_OVERFLOW_EN to report exact overflow; otherwise overflow is tied to 0.
module pow_var_exp_seq
  import pow_pkg::*;
#(
  parameter int WIDTH     = POW_WIDTH_DEFAULT,
  parameter int EXP_WIDTH = POW_EXP_WIDTH_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 run,
  input  logic [WIDTH-1:0]     n,
  input  logic [EXP_WIDTH-1:0] exp,
  output logic                 busy,
  output logic                 ready,
  output logic [WIDTH-1:0]     result,
  output logic                 overflow
);

`ifdef POW_VAR_EXP_SEQ_OVERFLOW_EN
  localparam int PROD_WIDTH = 2 * WIDTH;
`else
  localparam int PROD_WIDTH = WIDTH;
`endif

  pow_state_e            state_reg, state_next;
  logic [WIDTH-1:0]      acc_reg, base_reg, result_reg, acc_next;
  logic [EXP_WIDTH-1:0]  e_reg, e_shift;
  logic                  overflow_reg, ovf_next;
  logic [PROD_WIDTH-1:0] acc_prod, base_prod;
  logic                  accept, last_step;

  pow_mul_wide #(.WIDTH(WIDTH), .PROD_WIDTH(PROD_WIDTH)) u_mul_acc (
    .a    (acc_reg),
    .b    (base_reg),
    .prod (acc_prod)
  );

  pow_mul_wide #(.WIDTH(WIDTH), .PROD_WIDTH(PROD_WIDTH)) u_mul_base (
    .a    (base_reg),
    .b    (base_reg),
    .prod (base_prod)
  );

  assign e_shift   = e_reg >> 1;
  assign last_step = (e_shift == '0);
  assign accept    = run && (state_reg != POW_CALC);
  assign acc_next  = e_reg[0] ? acc_prod[WIDTH-1:0] : acc_reg;

`ifdef POW_VAR_EXP_SEQ_OVERFLOW_EN
  logic ovf_reg;

  // A squared base only matters if a later step will still multiply it in.
  assign ovf_next = ovf_reg
                  | (e_reg[0] && (|acc_prod[PROD_WIDTH-1:WIDTH]))
                  | (!last_step && (|base_prod[PROD_WIDTH-1:WIDTH]));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ovf_reg <= 1'b0;
    end else if (accept) begin
      ovf_reg <= 1'b0;
    end else if (state_reg == POW_CALC) begin
      ovf_reg <= ovf_next;
    end
  end
`else
  assign ovf_next = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg <= POW_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      POW_IDLE, POW_DONE: begin
        if (run) begin
          state_next = (exp != '0) ? POW_CALC : POW_DONE;
        end else begin
          state_next = POW_IDLE;
        end
      end
      POW_CALC: begin
        if (last_step) begin
          state_next = POW_DONE;
        end
      end
      default: state_next = POW_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      acc_reg      <= '0;
      base_reg     <= '0;
      e_reg        <= '0;
      result_reg   <= '0;
      overflow_reg <= 1'b0;
    end else if (accept) begin
      acc_reg  <= WIDTH'(1);
      base_reg <= n;
      e_reg    <= exp;
      // exp = 0 skips CALC entirely, so the result (n**0 = 1) is published here.
      if (exp == '0) begin
        result_reg   <= WIDTH'(1);
        overflow_reg <= 1'b0;
      end
    end else if (state_reg == POW_CALC) begin
      acc_reg  <= acc_next;
      base_reg <= base_prod[WIDTH-1:0];
      e_reg    <= e_shift;
      if (last_step) begin
        result_reg   <= acc_next;
        overflow_reg <= ovf_next;
      end
    end
  end

  assign busy     = (state_reg == POW_CALC);
  assign ready    = (state_reg == POW_DONE);
  assign result   = result_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_pow_var_exp_seq.sv
// Self-checking bench for pow_var_exp_seq: directed scenarios plus randomized operations
// checked against an exact-arithmetic power model.
module tb_pow_var_exp_seq;

  localparam int WIDTH     = 18;
  localparam int EXP_WIDTH = 4;
  localparam int MAX_WAIT  = 40;

  logic                 clock = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 run = 1'b0;
  logic [WIDTH-1:0]     n = '0;
  logic [EXP_WIDTH-1:0] exp = '0;
  logic                 busy;
  logic                 ready;
  logic [WIDTH-1:0]     result;
  logic                 overflow;

  int tests_run    = 0;
  int tests_failed = 0;

  pow_var_exp_seq #(.WIDTH(WIDTH), .EXP_WIDTH(EXP_WIDTH)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .run      (run),
    .n        (n),
    .exp      (exp),
    .busy     (busy),
    .ready    (ready),
    .result   (result),
    .overflow (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input longint got, input longint want);
    tests_run++;
    if (got != want) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference: repeated multiplication; overflow judged on the exact (untruncated) power.
  task automatic model(input longint unsigned nv, input int ev,
                       output longint res, output longint ovf);
    longint unsigned modulus;
    longint unsigned acc;
    longint unsigned exact;
    bit big;
    modulus = 64'd1 << WIDTH;
    acc = 1;
    exact = 1;
    big = 1'b0;
    for (int i = 0; i < ev; i++) begin
      acc = (acc * nv) % modulus;
      if (!big) begin
        exact = exact * nv;
        if (exact >= modulus) big = 1'b1;
      end
    end
    res = longint'(acc);
`ifdef POW_VAR_EXP_SEQ_OVERFLOW_EN
    ovf = longint'(big);
`else
    ovf = 0;
`endif
  endtask

  function automatic int bit_len(input int ev);
    int b;
    b = 0;
    for (int i = 0; i < EXP_WIDTH; i++) if (ev[i]) b = i + 1;
    return b;
  endfunction

  task automatic do_op(input string tag, input int unsigned nv, input int ev,
                       output longint got_result);
    longint er, eo, prev;
    int     b, cyc, busy_cnt;
    bit     unstable;
    model(longint'(nv), ev, er, eo);
    b = bit_len(ev);
    prev = longint'(result);
    run = 1'b1;
    n   = WIDTH'(nv);
    exp = EXP_WIDTH'(ev);
    tick();
    run = 1'b0;
    n   = WIDTH'($urandom);
    exp = EXP_WIDTH'($urandom);
    cyc = 0;
    busy_cnt = 0;
    unstable = 1'b0;
    while (!ready && cyc < MAX_WAIT) begin
      if (busy) busy_cnt++;
      if (longint'(result) != prev) unstable = 1'b1;
      tick();
      cyc++;
    end
    $display("[TB] %s n=%0d exp=%0d -> result=%0d overflow=%0d (model %0d/%0d) after %0d cycles",
             tag, nv, ev, result, overflow, er, eo, cyc);
    check({tag, "_latency"}, cyc, b);
    check({tag, "_busy_cycles"}, busy_cnt, b);
    check({tag, "_result_stable"}, unstable, 0);
    check({tag, "_busy_at_ready"}, busy, 0);
    check({tag, "_result"}, result, er);
    check({tag, "_overflow"}, overflow, eo);
    got_result = longint'(result);
    tick();
    check({tag, "_ready_pulse"}, ready, 0);
  endtask

  initial begin
    longint r;
    int     cyc;
    longint er, eo;

    // Reset state
    reset_n = 1'b0;
    tick();
    tick();
    check("reset_busy", busy, 0);
    check("reset_ready", ready, 0);
    check("reset_result", result, 0);
    check("reset_overflow", overflow, 0);
    reset_n = 1'b1;
    tick();

    // 1. 3**5
    do_op("pow3_5", 3, 5, r);
    check("pow3_5_const", r, 243);

    // 2. exp = 0
    do_op("pow7_0", 7, 0, r);
    check("pow7_0_const", r, 1);
    do_op("pow0_0", 0, 0, r);
    check("pow0_0_const", r, 1);

    // 3. wrap and overflow boundaries
    do_op("pow7_7", 7, 7, r);
    check("pow7_7_const", r, 37111);
    do_op("pow1_15", 1, 15, r);
    check("pow1_15_const", r, 1);
    do_op("pow0_15", 0, 15, r);
    do_op("pow_max_1", (1 << WIDTH) - 1, 1, r);
    do_op("pow512_2", 512, 2, r);

    // 4. run while busy is ignored
    run = 1'b1; n = WIDTH'(2); exp = EXP_WIDTH'(15);
    tick();
    run = 1'b0;
    tick();
    run = 1'b1; n = WIDTH'(9); exp = EXP_WIDTH'(3);
    tick();
    run = 1'b0;
    cyc = 2;
    while (!ready && cyc < MAX_WAIT) begin tick(); cyc++; end
    $display("[TB] busy_ignore result=%0d overflow=%0d after %0d cycles", result, overflow, cyc);
    check("busy_ignore_latency", cyc, 4);
    check("busy_ignore_result", result, 32768);
    check("busy_ignore_overflow", overflow, 0);
    tick();
    check("busy_ignore_no_restart_busy", busy, 0);
    check("busy_ignore_no_restart_ready", ready, 0);

    // 5. back-to-back with run held through ready
    run = 1'b1; n = WIDTH'(2); exp = EXP_WIDTH'(3);
    tick();
    n = WIDTH'(5); exp = EXP_WIDTH'(2);
    cyc = 0;
    while (!ready && cyc < MAX_WAIT) begin tick(); cyc++; end
    $display("[TB] b2b_first result=%0d after %0d cycles", result, cyc);
    check("b2b_first_latency", cyc, 2);
    check("b2b_first_result", result, 8);
    tick();
    run = 1'b0;
    check("b2b_no_idle_busy", busy, 1);
    check("b2b_no_idle_ready", ready, 0);
    cyc = 0;
    while (!ready && cyc < MAX_WAIT) begin tick(); cyc++; end
    $display("[TB] b2b_second result=%0d after %0d cycles", result, cyc);
    check("b2b_second_latency", cyc, 2);
    check("b2b_second_result", result, 25);
    tick();
    check("b2b_second_ready_pulse", ready, 0);

    // 6. reset mid-CALC
    run = 1'b1; n = WIDTH'(3); exp = EXP_WIDTH'(15);
    tick();
    run = 1'b0;
    tick();
    check("midrst_busy_before", busy, 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    $display("[TB] mid_calc_reset busy=%0d ready=%0d result=%0d overflow=%0d",
             busy, ready, result, overflow);
    check("midrst_busy", busy, 0);
    check("midrst_ready", ready, 0);
    check("midrst_result", result, 0);
    check("midrst_overflow", overflow, 0);
    tick();
    check("midrst_idle_busy", busy, 0);
    check("midrst_idle_ready", ready, 0);
    do_op("rst_recover", 4, 3, r);
    check("rst_recover_const", r, 64);

    // Randomized operations against the model
    for (int i = 0; i < 40; i++) begin
      int unsigned nv;
      int ev;
      nv = (i % 2 == 0) ? $urandom_range(0, 20) : ($urandom & ((1 << WIDTH) - 1));
      ev = $urandom_range(0, (1 << EXP_WIDTH) - 1);
      do_op($sformatf("rand%0d", i), nv, ev, r);
      if ($urandom_range(0, 3) == 0) tick();
    end

    model(2, 0, er, eo);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
